// File: rtl/fc_mac_seq.sv
// Sequential multiply-accumulate engine: K signed operand pairs per vector are
// accumulated onto a per-vector bias with one multiplier and one accumulator.
//
// state | meaning
// ACC   | accepting operand beats, accumulating products
// HOLD  | result valid on s, waiting for out_ready
module fc_mac_seq #(
   parameter int N = 8,
   parameter int K = 3,
   parameter int L = 2*N+K-1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   input  logic [L-1:0]        bias,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [L-1:0]        s
);

   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic {ACC, HOLD} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [L-1:0]          acc;
   logic signed [2*N-1:0] prod;
   logic [L-1:0]          prod_ext;
   logic [L-1:0]          base;
   logic [L-1:0]          sum;
   logic                  last_beat;

   assign in_ready  = (state == ACC);
   assign prod      = a * b;
   // Signed cast sign-extends the product; the L-bit add wraps on overflow.
   assign prod_ext  = L'(prod);
   assign base      = (cnt == '0) ? bias : acc;
   assign sum       = base + prod_ext;
   assign last_beat = (cnt == CW'(K-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= '0;
         s         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  if (last_beat) begin
                     s         <= sum;
                     out_valid <= 1'b1;
                     cnt       <= '0;
                     state     <= HOLD;
                  end else begin
                     acc <= sum;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_mac_seq.sv
// Self-checking bench for fc_mac_seq: a default-width instance and a 16-bit
// wrap instance share stimulus and are checked against an arithmetic model.
module tb_fc_mac_seq;

   localparam int N  = 8;
   localparam int K  = 3;
   localparam int L  = 2*N+K-1;
   localparam int LW = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                out_ready = 1'b0;
   logic signed [N-1:0] a = '0;
   logic signed [N-1:0] b = '0;
   logic [L-1:0]        bias = '0;
   logic [LW-1:0]       bias_w = '0;
   logic                in_ready, out_valid, in_ready_w, out_valid_w;
   logic [L-1:0]        s;
   logic [LW-1:0]       s_w;

   int checks = 0;
   int failures = 0;
   int va[K];
   int vb[K];
   int vg[K];

   always #5 clk = ~clk;

   fc_mac_seq #(.N(N), .K(K), .L(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bias(bias), .out_valid(out_valid), .out_ready(out_ready), .s(s)
   );

   fc_mac_seq #(.N(N), .K(K), .L(LW)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .bias(bias_w), .out_valid(out_valid_w), .out_ready(out_ready), .s(s_w)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wrap(input longint v, input int l);
      return 64'(v) & ((64'd1 << l) - 64'd1);
   endfunction

   task automatic scramble_inputs();
      a      = N'($urandom);
      b      = N'($urandom);
      bias   = L'($urandom);
      bias_w = LW'($urandom);
   endtask

   // Sends one vector from va/vb with vg idle cycles before each beat, then
   // holds out_ready low for bp cycles; release=0 leaves the engine in HOLD.
   task automatic run_vec(input longint bv, input int bp, input bit release_out);
      longint exp_sum;
      exp_sum = bv;
      for (int i = 0; i < K; i++) begin
         for (int g = 0; g < vg[i]; g++) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom);
            scramble_inputs();
            @(posedge clk); #1;
         end
         in_valid  = 1'b1;
         out_ready = 1'($urandom);
         a = N'(va[i]);
         b = N'(vb[i]);
         if (i == 0) begin
            bias   = bv[L-1:0];
            bias_w = bv[LW-1:0];
         end else begin
            bias   = L'($urandom);
            bias_w = LW'($urandom);
         end
         check_val("in_ready_beat", 64'(in_ready), 64'd1);
         check_val("in_ready_beat_w", 64'(in_ready_w), 64'd1);
         exp_sum += longint'(va[i]) * longint'(vb[i]);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      scramble_inputs();
      check_val("out_valid", 64'(out_valid), 64'd1);
      check_val("out_valid_w", 64'(out_valid_w), 64'd1);
      check_val("in_ready_hold", 64'(in_ready), 64'd0);
      check_val("s", 64'(s), wrap(exp_sum, L));
      check_val("s_w", 64'(s_w), wrap(exp_sum, LW));
      if (release_out) begin
         for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            scramble_inputs();
            in_valid = 1'($urandom);
            check_val("bp_s", 64'(s), wrap(exp_sum, L));
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check_val("post_hs_out_valid", 64'(out_valid), 64'd0);
         check_val("post_hs_in_ready", 64'(in_ready), 64'd1);
         check_val("post_hs_in_ready_w", 64'(in_ready_w), 64'd1);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_s", 64'(s), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic
      va = '{3, -5, 7}; vb = '{4, 6, -2}; vg = '{0, 0, 0};
      run_vec(0, 0, 1'b1);

      // bias and extremes, also the 16-bit wrap on u_dut_w
      va = '{-128, -128, -128}; vb = '{-128, -128, -128};
      run_vec(100, 0, 1'b1);
      va = '{-128, -128, -128}; vb = '{127, 127, 127};
      run_vec(0, 0, 1'b1);
      va = '{-128, -128, -128}; vb = '{-128, -128, -128};
      run_vec(0, 1, 1'b1);

      // gaps 1,0,0,1,0,1 then 5 cycles of backpressure
      va = '{3, -5, 7}; vb = '{4, 6, -2}; vg = '{0, 2, 1};
      run_vec(0, 5, 1'b1);

      // async reset while holding a result, between clock edges
      vg = '{0, 0, 0};
      run_vec(0, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_in_ready", 64'(in_ready), 64'd1);
      check_val("async_rst_out_valid", 64'(out_valid), 64'd0);
      check_val("async_rst_s", 64'(s), 64'd0);
      check_val("async_rst_s_w", 64'(s_w), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // mid-vector reset discards the partial sum
      in_valid = 1'b1; a = 8'sd10; b = 8'sd10; bias = L'(55); bias_w = LW'(55);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      va = '{1, 2, 3}; vb = '{1, 2, 3};
      run_vec(0, 0, 1'b1);

      // randomized vectors
      for (int t = 0; t < 40; t++) begin
         longint rb;
         for (int i = 0; i < K; i++) begin
            va[i] = int'($urandom_range(0, 255)) - 128;
            vb[i] = int'($urandom_range(0, 255)) - 128;
            vg[i] = int'($urandom_range(0, 2));
         end
         rb = longint'($urandom_range(0, (1 << L) - 1)) - longint'(1 << (L-1));
         run_vec(rb, int'($urandom_range(0, 3)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
